// File: rtl/mix_columns_iter.sv
// -----------------------------------------------------------------------------
// mix_columns_iter
//
// Iterative AES MixColumns / InvMixColumns engine. A 128-bit state is accepted
// through a valid/ready handshake, transformed COLS_PER_CYCLE columns per
// enabled clock inside a private work buffer, and the finished result is
// presented on a held output register until the consumer takes it.
//
// Parameters
//   WORD_SIZE       byte width, must be 8 (GF(2^8), polynomial 0x11b)
//   ARRAY_SIZE      bytes per state, must be 16
//   COLS_PER_CYCLE  columns transformed per enabled clock: 1, 2 or 4
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   enable     advance enable while BUSY (low = stall)
//   in_valid   input state offered
//   in_ready   high only while IDLE
//   decrypt    0 = MixColumns, 1 = InvMixColumns, sampled at accept
//   state      input state (column 0 in the MSBs, row 0 MSB of its column)
//   out_valid  state_out holds an unconsumed result
//   out_ready  consumer accepts the result
//   state_out  result register, only written on the completion edge
//   done       one-cycle pulse on the edge where out_valid rises
//   busy       high while BUSY
// -----------------------------------------------------------------------------
module mix_columns_iter #(
   parameter int WORD_SIZE      = 8,
   parameter int ARRAY_SIZE     = 16,
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            decrypt,
   input  logic [WORD_SIZE*ARRAY_SIZE-1:0] state,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WORD_SIZE*ARRAY_SIZE-1:0] state_out,
   output logic                            done,
   output logic                            busy
);

   localparam int         W        = WORD_SIZE * ARRAY_SIZE;
   localparam int         NCOL     = 4;
   // Counter value of the final column group; the step wraps to 0 when
   // COLS_PER_CYCLE = 4, which is harmless because there is only one group.
   localparam logic [1:0] LAST_CNT = 2'(NCOL - COLS_PER_CYCLE);
   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);

   generate
      if (WORD_SIZE != 8 || ARRAY_SIZE != 16 ||
          !(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
         $error("mix_columns_iter: illegal parameters (WORD_SIZE=8, ARRAY_SIZE=16, COLS_PER_CYCLE in {1,2,4})");
      end
   endgenerate

   // ------------------------------------------------------------------
   // GF(2^8) helpers
   // ------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One column, forward (02 03 01 01) or inverse (0e 0b 0d 09).
   // Every multiple is formed from 2x/4x/8x so both directions share the
   // same xtime chain per byte.
   function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
      logic [7:0]  s  [4];
      logic [7:0]  m2 [4];
      logic [7:0]  m4 [4];
      logic [7:0]  m8 [4];
      logic [31:0] res;
      logic [7:0]  fwd_b;
      logic [7:0]  inv_b;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         s[i]  = col[31-8*i -: 8];
         m2[i] = xtime(s[i]);
         m4[i] = xtime(m2[i]);
         m8[i] = xtime(m4[i]);
      end
      for (int r = 0; r < 4; r++) begin
         fwd_b = m2[r] ^ (m2[(r+1)%4] ^ s[(r+1)%4]) ^ s[(r+2)%4] ^ s[(r+3)%4];
         inv_b = (m8[r] ^ m4[r] ^ m2[r])
               ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ s[(r+1)%4])
               ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ s[(r+2)%4])
               ^ (m8[(r+3)%4] ^ s[(r+3)%4]);
         res[31-8*r -: 8] = inv ? inv_b : fwd_b;
      end
      return res;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         dec_q, dec_d;
   logic [W-1:0] work_q, work_d;
   logic [W-1:0] out_q, out_d;
   logic         out_valid_q, out_valid_d;
   logic         done_q, done_d;

   // ------------------------------------------------------------------
   // Column datapath: only COLS_PER_CYCLE mixers, steered by the counter
   // ------------------------------------------------------------------
   logic [31:0]  work_col [NCOL];
   logic [31:0]  upd_col  [NCOL];
   logic [1:0]   grp_idx  [COLS_PER_CYCLE];
   logic [31:0]  grp_mix  [COLS_PER_CYCLE];
   logic [W-1:0] work_upd;

   genvar gi;
   generate
      for (gi = 0; gi < NCOL; gi++) begin : g_col
         assign work_col[gi]                = work_q[W-1-32*gi -: 32];
         assign work_upd[W-1-32*gi -: 32]   = upd_col[gi];
      end
      for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_mix
         assign grp_idx[gi] = cnt_q + 2'(gi);
         assign grp_mix[gi] = mix_col(work_col[grp_idx[gi]], dec_q);
      end
   endgenerate

   // Work buffer with the current column group replaced by its transform.
   always_comb begin
      for (int k = 0; k < NCOL; k++) begin
         upd_col[k] = work_col[k];
      end
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
         upd_col[grp_idx[g]] = grp_mix[g];
      end
   end

   // ------------------------------------------------------------------
   // FSM: registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= ST_IDLE;
         cnt_q       <= 2'd0;
         dec_q       <= 1'b0;
         work_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         cnt_q       <= cnt_d;
         dec_q       <= dec_d;
         work_q      <= work_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      fsm_d       = fsm_q;
      cnt_d       = cnt_q;
      dec_d       = dec_q;
      work_d      = work_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      in_ready    = 1'b0;
      busy        = 1'b0;

      case (fsm_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               work_d = state;
               dec_d  = decrypt;
               cnt_d  = 2'd0;
               fsm_d  = ST_BUSY;
            end
         end
         ST_BUSY: begin
            busy = 1'b1;
            if (enable) begin
               work_d = work_upd;
               cnt_d  = cnt_q + STEP;
               // Result register is written only here, so partial
               // buffer contents never reach state_out.
               if (cnt_q == LAST_CNT) begin
                  out_d       = work_upd;
                  out_valid_d = 1'b1;
                  done_d      = 1'b1;
                  fsm_d       = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = ST_IDLE;
            end
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase
   end

   assign state_out = out_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
module tb_mix_columns_iter;

   localparam int NI = 3;   // instances with COLS_PER_CYCLE = 1, 2, 4

   localparam logic [127:0] V1  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] V2  = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] VC  = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] VCO = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         enable_a    [NI];
   logic         in_valid_a  [NI];
   logic         decrypt_a   [NI];
   logic         out_ready_a [NI];
   logic [127:0] state_a     [NI];
   logic         in_ready_a  [NI];
   logic         out_valid_a [NI];
   logic         done_a      [NI];
   logic         busy_a      [NI];
   logic [127:0] sout_a      [NI];

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         mix_columns_iter #(
            .WORD_SIZE      (8),
            .ARRAY_SIZE     (16),
            .COLS_PER_CYCLE ((gi == 0) ? 1 : ((gi == 1) ? 2 : 4))
         ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable_a[gi]),
            .in_valid  (in_valid_a[gi]),
            .in_ready  (in_ready_a[gi]),
            .decrypt   (decrypt_a[gi]),
            .state     (state_a[gi]),
            .out_valid (out_valid_a[gi]),
            .out_ready (out_ready_a[gi]),
            .state_out (sout_a[gi]),
            .done      (done_a[gi]),
            .busy      (busy_a[gi])
         );
      end
   endgenerate

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference arithmetic ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int p  = 0;
      int aa = int'(a);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa << 1;
         if ((aa & 32'h100) != 0) aa = aa ^ 32'h11b;
      end
      return p[7:0];
   endfunction

   function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic dec);
      logic [7:0]   cf [4];
      logic [127:0] o;
      logic [7:0]   acc;
      if (dec) begin
         cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
      end else begin
         cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
      end
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(cf[j], s[127-32*c-8*((r+j)%4) -: 8]);
            o[127-32*c-8*r -: 8] = acc;
         end
      end
      return o;
   endfunction

   function automatic int nlat(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 waiting for input, 1 computing (rem enabled edges left), 2 result held
   int           m_phase [NI];
   int           m_rem   [NI];
   logic [127:0] m_exp   [NI];
   logic [127:0] m_out   [NI];
   logic         m_valid [NI];
   logic         m_done  [NI];

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            m_phase[k] <= 0;
            m_rem[k]   <= 0;
            m_exp[k]   <= '0;
            m_out[k]   <= '0;
            m_valid[k] <= 1'b0;
            m_done[k]  <= 1'b0;
         end else begin
            m_done[k] <= 1'b0;
            case (m_phase[k])
               0: if (in_valid_a[k]) begin
                     m_exp[k]   <= mix_ref(state_a[k], decrypt_a[k]);
                     m_rem[k]   <= nlat(k);
                     m_phase[k] <= 1;
                  end
               1: if (enable_a[k]) begin
                     if (m_rem[k] == 1) begin
                        m_out[k]   <= m_exp[k];
                        m_valid[k] <= 1'b1;
                        m_done[k]  <= 1'b1;
                        m_phase[k] <= 2;
                     end else begin
                        m_rem[k] <= m_rem[k] - 1;
                     end
                  end
               default: if (out_ready_a[k]) begin
                     m_valid[k] <= 1'b0;
                     m_phase[k] <= 0;
                  end
            endcase
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("in_ready[%0d]", k),  128'(in_ready_a[k]),  128'(m_phase[k] == 0));
         chk($sformatf("busy[%0d]", k),      128'(busy_a[k]),      128'(m_phase[k] == 1));
         chk($sformatf("out_valid[%0d]", k), 128'(out_valid_a[k]), 128'(m_valid[k]));
         chk($sformatf("done[%0d]", k),      128'(done_a[k]),      128'(m_done[k]));
         chk($sformatf("state_out[%0d]", k), sout_a[k],            m_out[k]);
         if (done_a[k] === 1'b1)
            $display("txn dut=%0d result=%h", k, sout_a[k]);
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input int k, input logic [127:0] s, input logic d);
      @(posedge clk);
      #2;
      in_valid_a[k] = 1'b1;
      state_a[k]    = s;
      decrypt_a[k]  = d;
      @(posedge clk);   // accept edge
      #2;
      in_valid_a[k] = 1'b0;
   endtask

   // Edges after the accept edge until out_valid is seen; returns at edge+1.
   task automatic wait_out(input int k, output int edges);
      edges = 0;
      do begin
         @(posedge clk);
         edges++;
         #1;
      end while (out_valid_a[k] !== 1'b1 && edges < 40);
   endtask

   logic [127:0] r;
   logic [127:0] held;
   int           lat;
   int           guard;
   int           kk;

   initial begin
      for (int k = 0; k < NI; k++) begin
         enable_a[k] = 1'b1; in_valid_a[k] = 1'b0; decrypt_a[k] = 1'b0;
         out_ready_a[k] = 1'b1; state_a[k] = '0;
      end

      // model pins
      chk("model_fwd",  mix_ref(V1, 1'b0), V2);
      chk("model_inv",  mix_ref(V2, 1'b1), V1);
      chk("model_cols", mix_ref(VC, 1'b0), VCO);
      chk("model_cinv", mix_ref(VCO, 1'b1), VC);

      @(posedge clk);
      #1;
      chk("rst_state_out", sout_a[0], '0);
      chk("rst_out_valid", 128'(out_valid_a[0]), 128'(0));
      chk("rst_in_ready",  128'(in_ready_a[0]), 128'(1));
      @(posedge clk);
      #2 rst = 1'b0;

      // forward, C=1
      send(0, V1, 1'b0);
      wait_out(0, lat);
      chk("lat_c1", lat, 4);
      chk("fwd_c1", sout_a[0], V2);
      chk("done_c1", 128'(done_a[0]), 128'(1));
      @(posedge clk);
      #1;
      chk("done_pulse_c1", 128'(done_a[0]), 128'(0));
      chk("hs_valid_c1",   128'(out_valid_a[0]), 128'(0));
      chk("hs_ready_c1",   128'(in_ready_a[0]), 128'(1));

      // inverse, C=2
      send(1, V2, 1'b1);
      wait_out(1, lat);
      chk("lat_c2", lat, 2);
      chk("inv_c2", sout_a[1], V1);

      // column vectors, C=4, then invert the result back
      send(2, VC, 1'b0);
      wait_out(2, lat);
      chk("lat_c4", lat, 1);
      chk("fwd_c4", sout_a[2], VCO);
      r = sout_a[2];
      send(2, r, 1'b1);
      wait_out(2, lat);
      chk("lat_c4_inv", lat, 1);
      chk("inv_c4", sout_a[2], VC);

      // backpressure, C=1
      out_ready_a[0] = 1'b0;
      r = {$urandom, $urandom, $urandom, $urandom};
      send(0, r, 1'b0);
      wait_out(0, lat);
      held = sout_a[0];
      chk("bp_result", held, mix_ref(r, 1'b0));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         in_valid_a[0] = 1'b1;
         state_a[0]    = {$urandom, $urandom, $urandom, $urandom};
         #1;
         chk("bp_hold",     sout_a[0], held);
         chk("bp_valid",    128'(out_valid_a[0]), 128'(1));
         chk("bp_in_ready", 128'(in_ready_a[0]), 128'(0));
      end
      in_valid_a[0]  = 1'b0;
      out_ready_a[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 128'(out_valid_a[0]), 128'(0));
      chk("bp_release_ready", 128'(in_ready_a[0]), 128'(1));
      chk("bp_release_hold",  sout_a[0], held);

      // stall two cycles in BUSY and toggle decrypt mid-operation
      send(0, V1, 1'b0);
      enable_a[0]  = 1'b0;
      decrypt_a[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #2;
      enable_a[0] = 1'b1;
      wait_out(0, lat);
      chk("lat_stall", lat + 2, 6);
      chk("stall_result", sout_a[0], V2);
      decrypt_a[0] = 1'b0;

      // randomized transactions with random enable/out_ready/noise
      for (int t = 0; t < 30; t++) begin
         kk = int'($urandom_range(0, NI - 1));
         out_ready_a[kk] = 1'($urandom % 2);
         send(kk, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom % 2));
         guard = 0;
         while (m_phase[kk] != 0 && guard < 200) begin
            @(posedge clk);
            #2;
            enable_a[kk]    = ($urandom % 4) != 0;
            out_ready_a[kk] = 1'($urandom % 2);
            decrypt_a[kk]   = 1'($urandom % 2);
            in_valid_a[kk]  = 1'($urandom % 2);
            state_a[kk]     = {$urandom, $urandom, $urandom, $urandom};
            guard++;
         end
         in_valid_a[kk]  = 1'b0;
         enable_a[kk]    = 1'b1;
         out_ready_a[kk] = 1'b1;
         if (guard >= 200) chk("rand_drain_timeout", guard, 0);
      end

      // reset mid-operation, C=1
      @(posedge clk);
      send(0, V1, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_state_out", sout_a[0], '0);
      chk("mid_rst_valid",     128'(out_valid_a[0]), 128'(0));
      chk("mid_rst_done",      128'(done_a[0]), 128'(0));
      chk("mid_rst_busy",      128'(busy_a[0]), 128'(0));
      chk("mid_rst_ready",     128'(in_ready_a[0]), 128'(1));
      @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk("post_rst_valid", 128'(out_valid_a[0]), 128'(0));
         chk("post_rst_done",  128'(done_a[0]), 128'(0));
      end
      send(0, V1, 1'b0);
      wait_out(0, lat);
      chk("post_rst_lat", lat, 4);
      chk("post_rst_result", sout_a[0], V2);
      @(posedge clk);
      @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
